// File: rtl/servo_pwm_multi.sv
// Multi-channel servo PWM controller with an Avalon-MM slave register file.
// All channels share one frame counter; pulse widths update only at frame start.
module servo_pwm_multi #(
    parameter int CHANNELS   = 4,
    parameter int PERIOD_CYC = 1000000,
    parameter int MIN_PW     = 50000,
    parameter int MAX_PW     = 100000,
    parameter int PW_W       = $clog2(PERIOD_CYC)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [5:0]          address,
    input  logic                write,
    input  logic [31:0]         writedata,
    input  logic                read,
    output logic [31:0]         readdata,
    output logic                irq,
    output logic [CHANNELS-1:0] pwm
);

    localparam logic [PW_W-1:0] MIN_V  = PW_W'(MIN_PW);
    localparam logic [PW_W-1:0] MAX_V  = PW_W'(MAX_PW);
    localparam logic [PW_W-1:0] LAST_V = PW_W'(PERIOD_CYC - 1);

    function automatic logic [PW_W-1:0] clamp_pw(input logic [31:0] v);
        logic [PW_W-1:0] r;
        if (v < 32'(MIN_PW)) begin
            r = MIN_V;
        end else if (v > 32'(MAX_PW)) begin
            r = MAX_V;
        end else begin
            r = v[PW_W-1:0];
        end
        return r;
    endfunction

    // Saturating move toward the target; differences are compared so nothing can wrap.
    function automatic logic [PW_W-1:0] step_toward(input logic [PW_W-1:0] cur_v,
                                                     input logic [PW_W-1:0] tgt_v,
                                                     input logic [PW_W-1:0] step_v);
        logic [PW_W-1:0] r;
        if (step_v == '0) begin
            r = tgt_v;
        end else if (cur_v < tgt_v) begin
            r = ((tgt_v - cur_v) > step_v) ? (cur_v + step_v) : tgt_v;
        end else if (cur_v > tgt_v) begin
            r = ((cur_v - tgt_v) > step_v) ? (cur_v - step_v) : tgt_v;
        end else begin
            r = tgt_v;
        end
        return r;
    endfunction

    logic [PW_W-1:0]     cnt_r;
    logic [PW_W-1:0]     step_r;
    logic [CHANNELS-1:0] en_r, sweep_r, dir_down_r, irq_stat_r, irq_en_r, pwm_r;
    logic [PW_W-1:0]     target_r [CHANNELS];
    logic [PW_W-1:0]     lo_r     [CHANNELS];
    logic [PW_W-1:0]     hi_r     [CHANNELS];
    logic [PW_W-1:0]     cur_r    [CHANNELS];
    logic [31:0]         readdata_r;
    logic                irq_r;

    logic [PW_W-1:0]     tgt_s     [CHANNELS];
    logic [PW_W-1:0]     cur_nxt_s [CHANNELS];
    logic [CHANNELS-1:0] dir_nxt_s, set_s, w1c_s, stat_nxt_s, en_nxt_s;
    logic [31:0]         rd_mux_s;
    logic                frame_start_s;
    logic [5:0]          off_s;
    logic [3:0]          ch_idx_s;
    logic [1:0]          reg_sel_s;
    logic                ch_hit_s;

    assign frame_start_s = (cnt_r == '0);
    assign readdata      = readdata_r;
    assign irq           = irq_r;
    assign pwm           = pwm_r;

    // Decode the per-channel register window starting at word 4.
    always_comb begin
        off_s     = address - 6'd4;
        ch_idx_s  = off_s[5:2];
        reg_sel_s = off_s[1:0];
        ch_hit_s  = (address >= 6'd4) && ({28'd0, ch_idx_s} < 32'(CHANNELS));
    end

    // Per-channel effective target, next width and sweep endpoint detection.
    always_comb begin
        tgt_s     = '{default: '0};
        cur_nxt_s = '{default: '0};
        dir_nxt_s = dir_down_r;
        set_s     = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (sweep_r[c] && (lo_r[c] >= hi_r[c])) begin
                tgt_s[c] = lo_r[c];
            end else if (sweep_r[c]) begin
                tgt_s[c] = dir_down_r[c] ? lo_r[c] : hi_r[c];
            end else begin
                tgt_s[c] = target_r[c];
            end
            cur_nxt_s[c] = step_toward(cur_r[c], tgt_s[c], step_r);
            if (sweep_r[c] && (lo_r[c] < hi_r[c])) begin
                if (!dir_down_r[c] && (cur_nxt_s[c] == hi_r[c])) begin
                    dir_nxt_s[c] = 1'b1;
                    set_s[c]     = 1'b1;
                end else if (dir_down_r[c] && (cur_nxt_s[c] == lo_r[c])) begin
                    dir_nxt_s[c] = 1'b0;
                    set_s[c]     = 1'b1;
                end else begin
                    dir_nxt_s[c] = dir_down_r[c];
                end
            end else begin
                dir_nxt_s[c] = dir_down_r[c];
            end
        end
    end

    // Interrupt status/mask next state; an endpoint set beats a same-cycle clear.
    always_comb begin
        if (write && (address == 6'd2)) begin
            w1c_s = writedata[CHANNELS-1:0];
        end else begin
            w1c_s = '0;
        end
        if (write && (address == 6'd3)) begin
            en_nxt_s = writedata[CHANNELS-1:0];
        end else begin
            en_nxt_s = irq_en_r;
        end
        if (frame_start_s) begin
            stat_nxt_s = (irq_stat_r & ~w1c_s) | set_s;
        end else begin
            stat_nxt_s = irq_stat_r & ~w1c_s;
        end
    end

    // Read data multiplexer.
    always_comb begin
        rd_mux_s = '0;
        case (address)
            6'd0: begin
                rd_mux_s[CHANNELS-1:0]     = en_r;
                rd_mux_s[8 +: CHANNELS]    = sweep_r;
            end
            6'd1: rd_mux_s[PW_W-1:0]     = step_r;
            6'd2: rd_mux_s[CHANNELS-1:0] = irq_stat_r;
            6'd3: rd_mux_s[CHANNELS-1:0] = irq_en_r;
            default: begin
                for (int c = 0; c < CHANNELS; c++) begin
                    if (ch_hit_s && (ch_idx_s == 4'(c))) begin
                        case (reg_sel_s)
                            2'd0:    rd_mux_s[PW_W-1:0] = target_r[c];
                            2'd1:    rd_mux_s[PW_W-1:0] = lo_r[c];
                            2'd2:    rd_mux_s[PW_W-1:0] = hi_r[c];
                            default: rd_mux_s[PW_W-1:0] = cur_r[c];
                        endcase
                    end else begin
                        rd_mux_s = rd_mux_s;
                    end
                end
            end
        endcase
    end

    // Frame counter, register file, width update and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r      <= '0;
            step_r     <= '0;
            en_r       <= '0;
            sweep_r    <= '0;
            dir_down_r <= '0;
            irq_stat_r <= '0;
            irq_en_r   <= '0;
            pwm_r      <= '0;
            readdata_r <= 32'd0;
            irq_r      <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) begin
                target_r[c] <= MIN_V;
                lo_r[c]     <= MIN_V;
                hi_r[c]     <= MAX_V;
                cur_r[c]    <= MIN_V;
            end
        end else begin
            cnt_r      <= (cnt_r == LAST_V) ? '0 : cnt_r + PW_W'(1);
            irq_stat_r <= stat_nxt_s;
            irq_en_r   <= en_nxt_s;
            irq_r      <= |(stat_nxt_s & en_nxt_s);
            if (read) begin
                readdata_r <= rd_mux_s;
            end
            if (write) begin
                case (address)
                    6'd0: begin
                        en_r    <= writedata[CHANNELS-1:0];
                        sweep_r <= writedata[8 +: CHANNELS];
                    end
                    6'd1:    step_r <= writedata[PW_W-1:0];
                    default: ;
                endcase
            end
            for (int c = 0; c < CHANNELS; c++) begin
                pwm_r[c] <= en_r[c] && (cnt_r < cur_r[c]);
                if (frame_start_s) begin
                    cur_r[c]      <= cur_nxt_s[c];
                    dir_down_r[c] <= dir_nxt_s[c];
                end
                if (write && ch_hit_s && (ch_idx_s == 4'(c))) begin
                    case (reg_sel_s)
                        2'd0:    target_r[c] <= clamp_pw(writedata);
                        2'd1:    lo_r[c]     <= clamp_pw(writedata);
                        2'd2:    hi_r[c]     <= clamp_pw(writedata);
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_servo_pwm_multi.sv
// Bench for servo_pwm_multi: directed scenarios plus random bus traffic, compared
// every cycle against a behavioural model of the register map and frame rules.
module tb_servo_pwm_multi;

    localparam int CH   = 2;
    localparam int PER  = 100;
    localparam int MINP = 10;
    localparam int MAXP = 20;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  address = 6'd0;
    logic        write = 1'b0;
    logic [31:0] writedata = 32'd0;
    logic        read = 1'b0;
    logic [31:0] readdata;
    logic        irq;
    logic [1:0]  pwm;

    servo_pwm_multi #(
        .CHANNELS  (CH),
        .PERIOD_CYC(PER),
        .MIN_PW    (MINP),
        .MAX_PW    (MAXP)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .address  (address),
        .write    (write),
        .writedata(writedata),
        .read     (read),
        .readdata (readdata),
        .irq      (irq),
        .pwm      (pwm)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model state
    logic [31:0] m_cnt, m_step, m_en, m_sw, m_stat, m_ien, m_rd;
    logic [31:0] m_tgt [CH];
    logic [31:0] m_lo  [CH];
    logic [31:0] m_hi  [CH];
    logic [31:0] m_cur [CH];
    bit          m_dir [CH];
    logic [1:0]  m_pwm;
    logic        m_irq;

    function automatic logic [31:0] clampv(input logic [31:0] v);
        if (v < 32'(MINP)) return 32'(MINP);
        if (v > 32'(MAXP)) return 32'(MAXP);
        return v;
    endfunction

    function automatic logic [31:0] m_read(input logic [5:0] a);
        int ch, r;
        if (a == 6'd0) return (m_en & 32'h3) | ((m_sw & 32'h3) << 8);
        if (a == 6'd1) return m_step;
        if (a == 6'd2) return m_stat;
        if (a == 6'd3) return m_ien;
        if (a >= 6'd4 && a < 6'(4 + 4 * CH)) begin
            ch = (int'(a) - 4) / 4;
            r  = (int'(a) - 4) % 4;
            if (r == 0) return m_tgt[ch];
            if (r == 1) return m_lo[ch];
            if (r == 2) return m_hi[ch];
            return m_cur[ch];
        end
        return 32'd0;
    endfunction

    task automatic m_reset();
        m_cnt = 0; m_step = 0; m_en = 0; m_sw = 0; m_stat = 0; m_ien = 0; m_rd = 0;
        m_pwm = 2'b00; m_irq = 1'b0;
        for (int c = 0; c < CH; c++) begin
            m_tgt[c] = MINP; m_lo[c] = MINP; m_hi[c] = MAXP; m_cur[c] = MINP; m_dir[c] = 1'b0;
        end
    endtask

    // One clock edge of the specified behaviour, using the inputs currently applied.
    task automatic m_edge();
        logic [31:0] t, nc, setb, w1c;
        int ch;
        setb = 0;
        w1c  = 0;
        if (read) m_rd = m_read(address);
        for (int c = 0; c < CH; c++) m_pwm[c] = m_en[c] && (m_cnt < m_cur[c]);
        if (m_cnt == 0) begin
            for (int c = 0; c < CH; c++) begin
                if (m_sw[c]) t = (m_lo[c] >= m_hi[c]) ? m_lo[c] : (m_dir[c] ? m_lo[c] : m_hi[c]);
                else         t = m_tgt[c];
                if (m_step == 0)       nc = t;
                else if (m_cur[c] < t) nc = (m_cur[c] + m_step < t) ? m_cur[c] + m_step : t;
                else                   nc = (m_cur[c] > t + m_step) ? m_cur[c] - m_step : t;
                if (m_sw[c] && m_lo[c] < m_hi[c]) begin
                    if (!m_dir[c] && nc == m_hi[c]) begin m_dir[c] = 1'b1; setb |= (32'd1 << c); end
                    else if (m_dir[c] && nc == m_lo[c]) begin m_dir[c] = 1'b0; setb |= (32'd1 << c); end
                end
                m_cur[c] = nc;
            end
        end
        if (write) begin
            if (address == 6'd0) begin
                m_en = writedata & 32'h3;
                m_sw = (writedata >> 8) & 32'h3;
            end else if (address == 6'd1) m_step = writedata & 32'h7F;
            else if (address == 6'd2) w1c = writedata & 32'h3;
            else if (address == 6'd3) m_ien = writedata & 32'h3;
            else if (address < 6'(4 + 4 * CH)) begin
                ch = (int'(address) - 4) / 4;
                case ((int'(address) - 4) % 4)
                    0: m_tgt[ch] = clampv(writedata);
                    1: m_lo[ch]  = clampv(writedata);
                    2: m_hi[ch]  = clampv(writedata);
                    default: ;
                endcase
            end
        end
        m_stat = (m_stat & ~w1c) | setb;
        m_irq  = |(m_stat & m_ien);
        m_cnt  = (m_cnt == PER - 1) ? 0 : m_cnt + 1;
    endtask

    task automatic cycle();
        @(posedge clk);
        if (reset) m_reset();
        else m_edge();
        @(negedge clk);
        chk("pwm", 32'(pwm), 32'(m_pwm));
        chk("irq", 32'(irq), 32'(m_irq));
        chk("readdata", readdata, m_rd);
    endtask

    task automatic bus_write(input logic [5:0] a, input logic [31:0] d);
        address = a; writedata = d; write = 1'b1;
        cycle();
        write = 1'b0;
    endtask

    task automatic bus_read(input logic [5:0] a, output logic [31:0] d);
        address = a; read = 1'b1;
        cycle();
        read = 1'b0;
        d = readdata;
    endtask

    // Advance until just after the next frame-start update.
    task automatic wait_frame();
        int k = 0;
        do begin
            cycle();
            k++;
        end while (m_cnt != 1 && k < 2 * PER);
        if (m_cnt != 1) chk("frame_timeout", 32'd1, 32'd0);
    endtask

    logic [31:0] rv;
    int          hi0, hi1;
    logic [5:0]  rst_addr [12] = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd8, 6'd9, 6'd10, 6'd11};
    logic [31:0] rst_exp  [12] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd10, 32'd10, 32'd20, 32'd10,
                                   32'd10, 32'd10, 32'd20, 32'd10};
    logic [31:0] ramp_exp [5]  = '{32'd13, 32'd16, 32'd19, 32'd20, 32'd20};

    initial begin
        m_reset();
        repeat (3) cycle();
        chk("rst_pwm", 32'(pwm), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        reset = 1'b0;

        // 1: static pulse width
        bus_write(6'd0, 32'h1);
        bus_write(6'd4, 32'd15);
        bus_write(6'd1, 32'd0);
        wait_frame();
        wait_frame();
        hi0 = 0; hi1 = 0;
        for (int i = 0; i < PER; i++) begin
            cycle();
            hi0 += int'(pwm[0]);
            hi1 += int'(pwm[1]);
        end
        chk("width_ch0", 32'(hi0), 32'd15);
        chk("width_ch1", 32'(hi1), 32'd0);
        bus_read(6'd7, rv);
        chk("cur0_static", rv, 32'd15);

        // 2: ramp from 10 to 20 in steps of 3
        bus_write(6'd4, 32'd10);
        wait_frame();
        wait_frame();
        bus_write(6'd1, 32'd3);
        bus_write(6'd4, 32'd20);
        for (int i = 0; i < 5; i++) begin
            wait_frame();
            bus_read(6'd7, rv);
            chk("ramp_cur0", rv, ramp_exp[i]);
        end

        // 3: clamping on write
        bus_write(6'd4, 32'd5);
        bus_read(6'd4, rv);
        chk("clamp_lo", rv, 32'd10);
        bus_write(6'd4, 32'd500);
        bus_read(6'd4, rv);
        chk("clamp_hi", rv, 32'd20);

        // 4: sweep 12..16 with endpoint interrupts
        bus_write(6'd1, 32'd0);
        bus_write(6'd5, 32'd12);
        bus_write(6'd6, 32'd16);
        bus_write(6'd4, 32'd12);
        wait_frame();
        wait_frame();
        bus_write(6'd1, 32'd2);
        bus_write(6'd3, 32'd1);
        bus_write(6'd0, 32'h0101);
        wait_frame();
        bus_read(6'd7, rv);
        chk("sweep_14a", rv, 32'd14);
        chk("sweep_irq0", 32'(irq), 32'd0);
        wait_frame();
        bus_read(6'd7, rv);
        chk("sweep_16", rv, 32'd16);
        chk("sweep_irq_hi", 32'(irq), 32'd1);
        bus_read(6'd2, rv);
        chk("irq_stat", rv, 32'd1);
        bus_write(6'd2, 32'd1);
        chk("w1c_clear", 32'(irq), 32'd0);
        wait_frame();
        bus_read(6'd7, rv);
        chk("sweep_14b", rv, 32'd14);
        chk("sweep_irq1", 32'(irq), 32'd0);
        wait_frame();
        bus_read(6'd7, rv);
        chk("sweep_12", rv, 32'd12);
        chk("sweep_irq_lo", 32'(irq), 32'd1);

        // 5: disable mid-pulse, re-enable
        wait_frame();
        repeat (2) cycle();
        chk("pulse_high", 32'(pwm[0]), 32'd1);
        bus_write(6'd0, 32'h0100);
        cycle();
        chk("disable_low", 32'(pwm[0]), 32'd0);
        bus_write(6'd0, 32'h0101);
        wait_frame();
        cycle();
        chk("reenable_high", 32'(pwm[0]), 32'd1);

        // 6: asynchronous reset mid-pulse
        cycle();
        #1;
        reset = 1'b1;
        #1;
        chk("async_pwm", 32'(pwm), 32'd0);
        chk("async_irq", 32'(irq), 32'd0);
        chk("async_rd", readdata, 32'd0);
        m_reset();
        repeat (2) cycle();
        reset = 1'b0;
        address = 6'd7; read = 1'b1;
        chk("rd_before_edge", readdata, 32'd0);
        cycle();
        read = 1'b0;
        chk("rd_latency", readdata, 32'd10);
        for (int i = 0; i < 12; i++) begin
            bus_read(rst_addr[i], rv);
            chk("rst_reg", rv, rst_exp[i]);
        end

        // Random bus traffic
        for (int i = 0; i < 3000; i++) begin
            int op;
            op = int'($urandom_range(0, 9));
            if ($urandom_range(0, 19) == 0) address = 6'd45;
            else address = 6'($urandom_range(0, 13));
            writedata = (op % 2 == 1) ? ($urandom & 32'h0000_FFFF) : 32'($urandom_range(0, 30));
            write = (op < 3);
            read  = (op >= 3 && op < 6);
            cycle();
            write = 1'b0;
            read  = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
